score_display: RTL and testbench

- Consumes the 32-bit `score` value that the register file exports for the Whack-A-Mole game.
- Converts the score to BCD with a sequential double-dabble engine.
- Time-multiplexes the result onto the board's 8-digit common-anode seven-segment display.
- Sits directly downstream of the processor/regfile score output, between the core and the FPGA display pins.

---
 rtl/score_display.sv | 215 +++++++++++++++++++++
 tb/tb_score_display.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/score_display.sv
// score_display: converts the game score to packed BCD with a sequential
// double-dabble engine and multiplexes it onto an 8-digit common-anode display.
module score_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int NUM_DIGITS  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] score,
  input  logic        blank,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [31:0] bcd,
  output logic        busy
);

  localparam int                CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [2:0]        IDX_LAST  = 3'(NUM_DIGITS - 1);
  localparam logic [31:0]       SCORE_MAX = 32'd99_999_999;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic [31:0] clamp_score(input logic [31:0] v);
    logic [31:0] res;
    if (v[31]) begin
      res = 32'd0;
    end else if (v > SCORE_MAX) begin
      res = SCORE_MAX;
    end else begin
      res = v;
    end
    return res;
  endfunction

  function automatic logic [39:0] dabble_adjust(input logic [39:0] acc);
    logic [39:0] res;
    res = acc;
    for (int i = 0; i < 10; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = acc[4*i +: 4];
      end
    end
    return res;
  endfunction

  function automatic logic [2:0] find_msd(input logic [31:0] v);
    logic [2:0] res;
    res = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (v[4*i +: 4] != 4'd0) begin
        res = 3'(i);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] res;
    case (d)
      4'd0:    res = 7'h40;
      4'd1:    res = 7'h79;
      4'd2:    res = 7'h24;
      4'd3:    res = 7'h30;
      4'd4:    res = 7'h19;
      4'd5:    res = 7'h12;
      4'd6:    res = 7'h02;
      4'd7:    res = 7'h78;
      4'd8:    res = 7'h00;
      4'd9:    res = 7'h10;
      default: res = 7'h7F;
    endcase
    return res;
  endfunction

  state_t            r_state;
  state_t            w_next_state;
  logic              w_capture;
  logic [31:0]       r_last_score;
  logic [31:0]       r_bin;
  logic [39:0]       r_acc;
  logic [4:0]        r_iter;
  logic [31:0]       r_bcd;
  logic              r_busy;
  logic [39:0]       w_adj;
  logic              w_unused_adj_msb;
  logic [CNT_W-1:0]  r_ref_cnt;
  logic [2:0]        r_idx;
  logic [7:0]        r_an;
  logic [6:0]        r_seg;
  logic              r_dp;
  logic [2:0]        w_msd;
  logic [3:0]        w_nibble;
  logic              w_digit_on;

  // The clamp keeps the accumulator below 10^8, so its top bit never carries out.
  assign w_adj            = dabble_adjust(r_acc);
  assign w_unused_adj_msb = w_adj[39];

  assign w_msd      = find_msd(r_bcd);
  assign w_nibble   = r_bcd[{r_idx, 2'b00} +: 4];
  assign w_digit_on = !blank && (r_idx <= w_msd);

  // Conversion FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; a new conversion starts only when the raw score moved.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (score != r_last_score) begin
          w_capture    = 1'b1;
          w_next_state = S_SHIFT;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (r_iter == 5'd31) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_SHIFT;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Double-dabble datapath: adjust nibbles, then shift {acc, bin} left one bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last_score <= 32'd0;
      r_bin        <= 32'd0;
      r_acc        <= 40'd0;
      r_iter       <= 5'd0;
      r_bcd        <= 32'd0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_capture) begin
            r_last_score <= score;
            r_bin        <= clamp_score(score);
            r_acc        <= 40'd0;
            r_iter       <= 5'd0;
            r_busy       <= 1'b1;
          end
        end
        S_SHIFT: begin
          r_acc  <= {w_adj[38:0], r_bin[31]};
          r_bin  <= {r_bin[30:0], 1'b0};
          r_iter <= r_iter + 5'd1;
        end
        S_DONE: begin
          r_bcd  <= r_acc[31:0];
          r_busy <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  // Refresh divider, digit scan and registered anode/cathode drive.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ref_cnt <= '0;
      r_idx     <= 3'd0;
      r_an      <= 8'hFF;
      r_seg     <= 7'h7F;
      r_dp      <= 1'b1;
    end else begin
      if (r_ref_cnt == CNT_LAST) begin
        r_ref_cnt <= '0;
        r_idx     <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
      end else begin
        r_ref_cnt <= r_ref_cnt + CNT_W'(1);
      end
      if (w_digit_on) begin
        r_an  <= ~(8'd1 << r_idx);
        r_seg <= seg_encode(w_nibble);
      end else begin
        r_an  <= 8'hFF;
        r_seg <= 7'h7F;
      end
      r_dp <= 1'b1;
    end
  end

  assign an   = r_an;
  assign seg  = r_seg;
  assign dp   = r_dp;
  assign bcd  = r_bcd;
  assign busy = r_busy;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: table-driven conversions with a
// scoreboard queue, digit-scan checks, and hand-written reset/blank/retrigger cases.
module tb_score_display;

  localparam int RDIV = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] score = 32'd0;
  logic        blank = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [31:0] bcd;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic [31:0] score;
    logic [31:0] exp_bcd;
  } vec_t;

  vec_t vecs[10];

  score_display #(.REFRESH_DIV(RDIV), .NUM_DIGITS(8)) dut (
    .clock(clock), .reset(reset), .score(score), .blank(blank),
    .an(an), .seg(seg), .dp(dp), .bcd(bcd), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_score(input logic [31:0] s, input logic [31:0] e, input bit push);
    score = s;
    if (push) sb_q.push_back(e);
  endtask

  // Waits for one conversion; optionally changes the score on busy cycle inj_at.
  task automatic wait_result(input string name, input int inj_at,
                             input logic [31:0] inj_s, input logic [31:0] inj_e);
    int edges = 0;
    int busy_cnt = 0;
    logic [31:0] exp;
    do begin
      tick();
      edges++;
    end while (!busy && edges < 5);
    check({name, " capture edge"}, 32'(edges), 32'd1);
    while (busy && busy_cnt < 60) begin
      busy_cnt++;
      if (busy_cnt == inj_at) begin
        score = inj_s;
        sb_q.push_back(inj_e);
      end
      tick();
    end
    check({name, " busy cycles"}, 32'(busy_cnt), 32'd33);
    if (sb_q.size() == 0) begin
      check({name, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      exp = sb_q.pop_front();
      check({name, " bcd"}, bcd, exp);
    end
  endtask

  // Syncs to the start of slot 0 and compares a full 8-slot scan.
  task automatic display_check(input string name, input logic [31:0] exp_bcd);
    int msd = 0;
    int guard;
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    for (int i = 1; i < 8; i++) if (exp_bcd[4*i +: 4] != 4'd0) msd = i;
    guard = 0;
    while (an == 8'hFE && guard < 100) begin tick(); guard++; end
    guard = 0;
    while (an != 8'hFE && guard < 100) begin tick(); guard++; end
    check({name, " sync slot0"}, 32'(an), 32'hFE);
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < RDIV; c++) begin
        if (s <= msd) begin
          exp_an  = ~(8'd1 << s);
          exp_seg = seg_of(exp_bcd[4*s +: 4]);
        end else begin
          exp_an  = 8'hFF;
          exp_seg = 7'h7F;
        end
        check($sformatf("%s slot%0d an/seg", name, s), 32'({an, seg}), 32'({exp_an, exp_seg}));
        tick();
      end
    end
  endtask

  initial begin
    bit seen;
    int guard;

    vecs[0] = '{32'd1234,        32'h00001234};
    vecs[1] = '{32'hFFFFFFFF,    32'h00000000};
    vecs[2] = '{32'd150_000_000, 32'h99999999};
    vecs[3] = '{32'd100_000_000, 32'h99999999};
    vecs[4] = '{32'd99_999_999,  32'h99999999};
    vecs[5] = '{32'd42,          32'h00000042};
    vecs[6] = '{32'h80000000,    32'h00000000};
    vecs[7] = '{32'd9,           32'h00000009};
    vecs[8] = '{32'd10_000_000,  32'h10000000};
    vecs[9] = '{32'd87_654_321,  32'h87654321};

    #2 reset = 1'b0;
    repeat (3) tick();
    check("reset an", 32'(an), 32'hFF);
    check("reset seg", 32'(seg), 32'h7F);
    check("reset dp", 32'(dp), 32'd1);
    check("reset bcd", bcd, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    seen = 1'b0;
    repeat (10) begin tick(); seen |= busy; end
    check("score0 no conversion", 32'(seen), 32'd0);
    display_check("zero", 32'd0);

    foreach (vecs[k]) begin
      drive_score(vecs[k].score, vecs[k].exp_bcd, 1'b1);
      wait_result($sformatf("vec%0d", k), 0, 32'd0, 32'd0);
      display_check($sformatf("vec%0d disp", k), vecs[k].exp_bcd);
    end

    // Unchanged score must not retrigger.
    seen = 1'b0;
    repeat (10) begin tick(); seen |= busy; end
    check("same score idle", 32'(seen), 32'd0);

    // Score change on the 10th SHIFT cycle: old result first, then the new one.
    drive_score(32'd1234, 32'h00001234, 1'b1);
    wait_result("retrig first", 10, 32'd56, 32'h00000056);
    wait_result("retrig second", 0, 32'd0, 32'd0);
    display_check("retrig disp", 32'h00000056);

    // Asynchronous reset in the middle of a conversion.
    drive_score(32'd777, 32'd0, 1'b0);
    guard = 0;
    do begin tick(); guard++; end while (!busy && guard < 5);
    repeat (19) tick();
    check("pre-reset busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("async reset an", 32'(an), 32'hFF);
    check("async reset seg", 32'(seg), 32'h7F);
    check("async reset bcd", bcd, 32'd0);
    check("async reset busy", 32'(busy), 32'd0);
    score = 32'd7;
    repeat (2) tick();
    @(negedge clock);
    reset = 1'b1;
    sb_q.push_back(32'd7);
    wait_result("post reset", 0, 32'd0, 32'd0);
    display_check("post reset disp", 32'd7);

    // Blanking forces all digits off while the scan keeps running.
    drive_score(32'd42, 32'h00000042, 1'b1);
    wait_result("blank conv", 0, 32'd0, 32'd0);
    display_check("pre blank", 32'h00000042);
    blank = 1'b1;
    tick();
    check("blank an", 32'(an), 32'hFF);
    check("blank seg", 32'(seg), 32'h7F);
    seen = 1'b0;
    repeat (12) begin tick(); seen |= (an != 8'hFF) || (seg != 7'h7F); end
    check("blank held", 32'(seen), 32'd0);
    blank = 1'b0;
    display_check("post blank", 32'h00000042);
    check("dp off", 32'(dp), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
